// File: rtl/bcd2bi.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Results saturate to OUT_W bits; an invalid nibble reports err_bcd with bin forced to zero.
module bcd2bi #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned RES_W  = 10,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin,
  output logic                  ovf,
  output logic                  err_bcd
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(RES_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   dig_q, dig_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  bin_q, bin_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic                  bad_nibble;
  logic                  last_shift;
  logic                  sat;
  logic [BcdW+RES_W-1:0] shifted;
  logic [BcdW-1:0]       dig_adj;
  logic [RES_W-1:0]      acc_sh;

  assign busy    = (state_q == StShift);
  assign done    = (state_q == StDone);
  assign bin     = bin_q;
  assign ovf     = ovf_q;
  assign err_bcd = err_q;

  assign last_shift = (cnt_q == CntW'(RES_W - 1));

  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[i*4 +: 4] > 4'd9) bad_nibble = 1'b1;
    end
  end

  // Shift right first, then correct any digit that landed at 8 or above.
  always_comb begin
    shifted = {dig_q, acc_q} >> 1;
    acc_sh  = shifted[RES_W-1:0];
    dig_adj = shifted[BcdW+RES_W-1:RES_W];
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_adj[i*4 +: 4] >= 4'd8) dig_adj[i*4 +: 4] = dig_adj[i*4 +: 4] - 4'd3;
    end
    sat = |(acc_sh >> OUT_W);
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          dig_d = bcd_in;
          acc_d = '0;
          cnt_d = '0;
          if (bad_nibble) begin
            err_d   = 1'b1;
            bin_d   = '0;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        dig_d = dig_adj;
        acc_d = acc_sh;
        cnt_d = cnt_q + 1'b1;
        if (last_shift) begin
          state_d = StDone;
          err_d   = 1'b0;
          ovf_d   = sat;
          bin_d   = sat ? {OUT_W{1'b1}} : acc_sh[OUT_W-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dig_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Every digit must have been fully drained into the binary register.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StShift && last_shift) |-> (dig_adj == '0))
    else $error("bcd2bi: digit register not empty after final shift");

endmodule

// File: tb/tb_bcd2bi.sv
// Self-checking bench for bcd2bi: directed scenarios, exhaustive 000..999 sweep and
// random patterns (including invalid nibbles) against an arithmetic reference model.
module tb_bcd2bi;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  bin;
  logic        ovf;
  logic        err_bcd;

  int checks = 0;
  int errors = 0;

  bcd2bi #(
    .DIGITS (3),
    .RES_W  (10),
    .OUT_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin     (bin),
    .ovf     (ovf),
    .err_bcd (err_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, then range/validity rules applied with plain arithmetic.
  function automatic void model(input logic [11:0] b, output logic [7:0] eb,
                                output logic eo, output logic ee);
    int v = 0;
    int p = 1;
    logic [3:0] nib;
    ee = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nib = b[i*4 +: 4];
      if (nib > 4'd9) ee = 1'b1;
      v += int'(nib) * p;
      p *= 10;
    end
    eo = 1'b0;
    eb = 8'd0;
    if (!ee) begin
      if (v > 255) begin
        eo = 1'b1;
        eb = 8'hFF;
      end else begin
        eb = v[7:0];
      end
    end
  endfunction

  // Launch one conversion; optionally re-pulse start at a given cycle with other data.
  // lat is the cycle (1-based after the accepting edge) on which done was seen, 0 on timeout.
  task automatic conv(input logic [11:0] b, input int pulse_at, output int lat, output int bcnt);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(posedge clk);
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (pulse_at != 0 && c == pulse_at);
      bcd_in = start ? 12'h999 : 12'hABC;
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [11:0] b);
    int lat, bcnt;
    logic [7:0] eb;
    logic eo, ee;
    model(b, eb, eo, ee);
    conv(b, 0, lat, bcnt);
    chk({tag, "_lat"}, lat, ee ? 1 : 11);
    chk({tag, "_bin"}, bin, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_err"}, err_bcd, ee);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [11:0] b;
    logic [7:0] eb;
    logic eo, ee;

    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 12'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err_bcd, 0);

    // 1: 255 converts in 11 cycles with busy for 10
    conv(12'h255, 0, lat, bcnt);
    chk("t1_lat", lat, 11);
    chk("t1_busy_cycles", bcnt, 10);
    chk("t1_bin", bin, 8'hFF);
    chk("t1_ovf", ovf, 0);
    chk("t1_err", err_bcd, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    bcd_in = 12'h001;
    repeat (3) @(negedge clk);
    chk("t1_hold_bin", bin, 8'hFF);

    // 2-4: directed values
    run_check("t2_000", 12'h000);
    run_check("t2_128", 12'h128);
    run_check("t3_256", 12'h256);
    run_check("t3_999", 12'h999);
    run_check("t4_1A3", 12'h1A3);
    run_check("t4_F00", 12'hF00);

    // 5: start re-pulsed in SHIFT and in DONE is ignored
    conv(12'h200, 4, lat, bcnt);
    chk("t5_lat", lat, 11);
    chk("t5_bin", bin, 8'd200);
    chk("t5_ovf", ovf, 0);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done_ignored", done, 0);
    chk("t5_busy_ignored", busy, 0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("t5_no_second_conv", dcnt, 0);
    chk("t5_bin_kept", bin, 8'd200);

    // 6: reset during shift 5 aborts without done
    @(negedge clk);
    bcd_in = 12'h777;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_bin", bin, 0);
    chk("t6_ovf", ovf, 0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("t6_no_done", dcnt, 0);
    run_check("t6_042", 12'h042);
    chk("t6_042_val", bin, 8'h2A);

    // Exhaustive valid sweep
    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      model(b, eb, eo, ee);
      conv(b, 0, lat, bcnt);
      chk("sweep_lat", lat, 11);
      chk("sweep_bin", bin, eb);
      chk("sweep_ovf", ovf, eo);
      chk("sweep_err", err_bcd, 0);
    end

    // Random patterns, invalid nibbles allowed
    for (int n = 0; n < 200; n++) begin
      b = 12'($urandom);
      run_check("rand", b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
